// File: rtl/instruction_fetch_pkg.sv
// Purpose : shared definitions for the instruction fetch unit and the control unit.
// Contents: fetch FSM state encoding, PC increment constant, 7-bit RV opcode constants.
// Config  : none here; IF_MISALIGN_CHECK_EN is consumed by instruction_fetch and pc_next.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } if_state_t;

  localparam int PC_INCR = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Purpose : next-PC selection (pc+4 or redirect) with target alignment handling.
// Latency : purely combinational.
// Ports   : pc, pc_src, branch_target in; next_pc, target_misaligned out.
// Config  : IF_MISALIGN_CHECK_EN -> misaligned redirect is reported and pc kept;
//           otherwise the low two target bits are cleared.
import instruction_fetch_pkg::*;

module pc_next #(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] pc,
  input  logic                pc_src,
  input  logic [WORDSIZE-1:0] branch_target,
  output logic [WORDSIZE-1:0] next_pc,
  output logic                target_misaligned
);

  logic [WORDSIZE-1:0] incr_pc;

  // Plain modular add: wrap past the top of the address space is silent.
  assign incr_pc = pc + WORDSIZE'(PC_INCR);

`ifdef IF_MISALIGN_CHECK_EN
  always_comb begin
    target_misaligned = 1'b0;
    next_pc           = incr_pc;
    if (pc_src) begin
      if (branch_target[1:0] != 2'b00) begin
        // Trap: keep the PC pointing at the offending instruction.
        target_misaligned = 1'b1;
        next_pc           = pc;
      end else begin
        next_pc = branch_target;
      end
    end
  end
`else
  assign target_misaligned = 1'b0;
  assign next_pc = pc_src ? (branch_target & ~WORDSIZE'(3)) : incr_pc;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Purpose : fetches one instruction at a time and holds it until the control unit finishes it.
// Latency : instruction valid one cycle after imem_ack; imem_req held until acked.
// Ports   : clk/reset; imem_req/imem_addr/imem_ack/imem_rdata memory side;
//           finished/pc_src/branch_target from control; instruction/opcode/pc/
//           instr_valid/instret/misaligned out.
// Config  : IF_MISALIGN_CHECK_EN enables the misaligned-redirect trap (HALT state).
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter int                   WORDSIZE         = 64,
  parameter int                   INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        finished,
  input  logic                        pc_src,
  input  logic [WORDSIZE-1:0]         branch_target,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [6:0]                  opcode,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        instr_valid,
  output logic [WORDSIZE-1:0]         instret,
  output logic                        misaligned
);

  if_state_t           state_q, state_d;
  logic [WORDSIZE-1:0] next_pc;
  logic                target_misaligned;
  logic                fetch_done;
  logic                retire;

  pc_next #(.WORDSIZE(WORDSIZE)) u_pc_next (
    .pc                (pc),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .next_pc           (next_pc),
    .target_misaligned (target_misaligned)
  );

  // Handshakes only count in their own state; stray pulses elsewhere are dropped.
  assign fetch_done = (state_q == FETCH) && imem_ack;
  assign retire     = (state_q == HOLD) && finished;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ack) state_d = HOLD;
      HOLD:  if (finished) state_d = target_misaligned ? HALT : FETCH;
      HALT:  state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      instret     <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_done) instruction <= imem_rdata;
      if (retire) begin
        pc      <= next_pc;
        instret <= instret + WORDSIZE'(1);
      end
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                               misaligned <= 1'b0;
    else if (retire && target_misaligned)    misaligned <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc;
  // HOLD is entered exactly on the cycle after the ack, so validity follows state.
  assign instr_valid = (state_q == HOLD);
  assign opcode      = instruction[6:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose : self-checking bench for instruction_fetch (directed steps plus random transactions).
// Latency : a transaction is fetch (ack after N cycles) followed by retire (finished).
// Config  : honours IF_MISALIGN_CHECK_EN for the misaligned-redirect expectations.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int W  = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          finished;
  logic          pc_src;
  logic [W-1:0]  branch_target;
  logic [IW-1:0] instruction;
  logic [6:0]    opcode;
  logic [W-1:0]  pc;
  logic          instr_valid;
  logic [W-1:0]  instret;
  logic          misaligned;

  instruction_fetch #(.WORDSIZE(W), .INSTRUCTION_SIZE(IW), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .finished      (finished),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .instruction   (instruction),
    .opcode        (opcode),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .instret       (instret),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural view of the fetch unit.
  logic [W-1:0]  exp_pc;
  logic [W-1:0]  exp_instret;
  logic [IW-1:0] exp_instr;
  logic          exp_halt;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; finished = 1'b0; pc_src = 1'b0;
    @(negedge clk);
    exp_pc = '0; exp_instret = '0; exp_instr = '0; exp_halt = 1'b0;
    chk("rst_req",        W'(imem_req),    '0);
    chk("rst_valid",      W'(instr_valid), '0);
    chk("rst_pc",         pc,              exp_pc);
    chk("rst_instr",      W'(instruction), '0);
    chk("rst_instret",    instret,         '0);
    chk("rst_misaligned", W'(misaligned),  '0);
    reset = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", W'(imem_req), W'(1));
  endtask

  // Memory side: hold off the ack for 'delay' cycles, optionally pulsing finished.
  task automatic fetch(input int delay, input logic [IW-1:0] data, input bit pulse_fin);
    wait_req();
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      finished = pulse_fin ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("fetch_req_held", W'(imem_req), W'(1));
      chk("fetch_addr",     imem_addr,    exp_pc);
      @(negedge clk);
    end
    chk("fetch_addr_ack", imem_addr, exp_pc);
    finished = 1'b0; imem_ack = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_ack  = 1'b0;
    exp_instr = data;
    chk("fetch_valid",   W'(instr_valid), W'(1));
    chk("fetch_instr",   W'(instruction), W'(exp_instr));
    chk("fetch_opcode",  W'(opcode),      W'(exp_instr[6:0]));
    chk("fetch_pc",      pc,              exp_pc);
    chk("fetch_req_off", W'(imem_req),    '0);
    chk("fetch_instret", instret,         exp_instret);
  endtask

  // Control side: stall 'hold' cycles (with stray acks), then finish the instruction.
  task automatic retire(input int hold, input logic src, input logic [W-1:0] target);
    for (int i = 0; i < hold; i++) begin
      finished = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_instr", W'(instruction), W'(exp_instr));
      chk("hold_pc",    pc,              exp_pc);
      chk("hold_valid", W'(instr_valid), W'(1));
      chk("hold_req",   W'(imem_req),    '0);
    end
    imem_ack = 1'b0; finished = 1'b1; pc_src = src; branch_target = target;
    @(negedge clk);
    finished = 1'b0; pc_src = 1'b0;
    exp_instret = exp_instret + 1;
    if (src) begin
`ifdef IF_MISALIGN_CHECK_EN
      if (target[1:0] != 2'b00) exp_halt = 1'b1;
      else                      exp_pc   = target;
`else
      exp_pc = {target[W-1:2], 2'b00};
`endif
    end else begin
      exp_pc = exp_pc + 4;
    end
    chk("ret_valid",   W'(instr_valid), '0);
    chk("ret_instret", instret,         exp_instret);
    chk("ret_pc",      pc,              exp_pc);
    chk("ret_mis",     W'(misaligned),  W'(exp_halt));
    if (exp_halt) chk("ret_req_halt", W'(imem_req), '0);
    else begin
      chk("ret_req",  W'(imem_req), W'(1));
      chk("ret_addr", imem_addr,    exp_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] tgt;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; finished = 1'b0;
    pc_src = 1'b0; branch_target = '0;
    exp_halt = 1'b0;

    apply_reset();

    // First fetch from reset: addi x1,x0,10 at address 0.
    fetch(1, 32'h00A00093, 1'b0);
    chk("first_opcode", W'(opcode), W'(OPC_OP_IMM));
    chk("first_pc",     pc,         '0);

    // Sequential step from 0x100.
    retire(2, 1'b1, 64'h100);
    fetch(0, $urandom, 1'b0);
    retire(1, 1'b0, 64'h0);
    chk("seq_addr", imem_addr, 64'h104);
    chk("seq_instret", instret, 64'd2);

    // Slow memory with finished pulses that must be ignored.
    fetch(5, $urandom, 1'b1);
    retire(0, 1'b1, 64'h2000);
    chk("redirect_addr", imem_addr, 64'h2000);

    // Misaligned redirect.
    fetch(0, $urandom, 1'b0);
    retire(0, 1'b1, 64'h2002);
`ifdef IF_MISALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; finished = 1'b1;
      @(negedge clk);
      chk("halt_req",   W'(imem_req),    '0);
      chk("halt_valid", W'(instr_valid), '0);
      chk("halt_mis",   W'(misaligned),  W'(1));
    end
    imem_ack = 1'b0; finished = 1'b0;
    apply_reset();
`else
    chk("mask_addr", imem_addr, 64'h2000);
`endif

    // PC wrap at the top of the address space.
    fetch(0, $urandom, 1'b0);
    retire(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(2, $urandom, 1'b0);
    retire(0, 1'b0, 64'h0);
    chk("wrap_addr", imem_addr, '0);

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      tgt = {$urandom, $urandom};
`ifdef IF_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      fetch($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
      retire($urandom_range(0, 3), 1'($urandom_range(0, 1)), tgt);
    end

    // Reset in the middle of a fetch, coincident with an ack.
    wait_req();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0;
    exp_pc = '0; exp_instret = '0; exp_instr = '0;
    chk("midrst_instr",   W'(instruction), '0);
    chk("midrst_pc",      pc,              '0);
    chk("midrst_valid",   W'(instr_valid), '0);
    chk("midrst_req",     W'(imem_req),    '0);
    chk("midrst_instret", instret,         '0);
    fetch(1, 32'h0000_0013, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
